// File: rtl/bju_resolve.sv
// Branch/jump resolution unit: resolves up to LANES control-flow instructions per cycle,
// raises a one-cycle redirect on the oldest mispredict, keeps history and queues predictor updates.
module bju_resolve #(
   parameter int LANES     = 2,
   parameter int GHSR_W    = 8,
   parameter int UPD_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush_in,
   input  logic [LANES-1:0]      lane_valid,
   input  logic [LANES-1:0]      is_branch,
   input  logic [LANES-1:0]      is_jump,
   input  logic [LANES-1:0]      is_jumpr,
   input  logic [3*LANES-1:0]    funct3,
   input  logic [32*LANES-1:0]   pc,
   input  logic [32*LANES-1:0]   rs1,
   input  logic [32*LANES-1:0]   rs2,
   input  logic [32*LANES-1:0]   imm,
   input  logic [LANES-1:0]      pred_taken,
   input  logic [LANES-1:0]      pred_hit,
   input  logic [32*LANES-1:0]   pred_target,
   output logic                  redirect_valid,
   output logic [31:0]           redirect_pc,
   output logic [32*LANES-1:0]   link_pc,
   output logic [GHSR_W-1:0]     ghsr_restore,
   output logic                  upd_valid,
   input  logic                  upd_ready,
   output logic [31:0]           upd_pc,
   output logic [31:0]           upd_target,
   output logic                  upd_taken,
   output logic                  upd_is_cond,
   output logic                  upd_almost_full,
   output logic [31:0]           resolved_cnt,
   output logic [31:0]           mispredict_cnt,
   output logic [31:0]           drop_cnt
);
   localparam int PTR_W = $clog2(UPD_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   function automatic logic branch_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  return (a == b);
         3'b001:  return (a != b);
         3'b100:  return ($signed(a) < $signed(b));
         3'b101:  return !($signed(a) < $signed(b));
         3'b110:  return (a < b);
         3'b111:  return !(a < b);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   logic [LANES-1:0]  w_active, w_taken, w_misp, w_surv, w_push_en;
   logic [31:0]       w_target [LANES];
   logic [PTR_W-1:0]  w_push_idx [LANES];
   logic              w_found, w_pop;
   logic [GHSR_W-1:0] w_ghsr_next;
   logic [31:0]       w_rpc_next;
   logic [OCC_W-1:0]  w_surv_n, w_free, w_acc, w_drop, w_occ_next;

   logic [GHSR_W-1:0] r_ghsr, r_ghsr_restore;
   logic              r_redirect_valid, r_almost_full;
   logic [31:0]       r_redirect_pc, r_resolved, r_misp, r_drop;
   logic [32*LANES-1:0] r_link;
   logic [PTR_W-1:0]  r_rptr, r_wptr;
   logic [OCC_W-1:0]  r_occ;
   logic [31:0]       r_mem_pc [UPD_DEPTH];
   logic [31:0]       r_mem_tgt [UPD_DEPTH];
   logic [UPD_DEPTH-1:0] r_mem_taken, r_mem_cond;

   // Per-lane condition, target and mispredict decode.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         w_active[l] = lane_valid[l] & (is_branch[l] | is_jump[l] | is_jumpr[l]) & ~flush_in;
         if (is_branch[l]) begin
            w_taken[l]  = branch_cond(funct3[3*l +: 3], rs1[32*l +: 32], rs2[32*l +: 32]);
            w_target[l] = w_taken[l] ? (pc[32*l +: 32] + imm[32*l +: 32]) : (pc[32*l +: 32] + 32'd4);
         end else if (is_jump[l]) begin
            w_taken[l]  = 1'b1;
            w_target[l] = pc[32*l +: 32] + imm[32*l +: 32];
         end else begin
            w_taken[l]  = 1'b1;
            w_target[l] = (rs1[32*l +: 32] + imm[32*l +: 32]) & 32'hFFFF_FFFE;
         end
         w_misp[l] = w_active[l] & ((w_taken[l] != pred_taken[l]) |
                     (w_taken[l] & pred_taken[l] & pred_hit[l] & (pred_target[32*l +: 32] != w_target[l])));
      end
   end

   // Oldest-mispredict selection, squash of younger lanes and history update.
   // Without a mispredict, the redirect PC tracks the youngest surviving lane's target.
   always_comb begin
      w_found     = 1'b0;
      w_surv      = '0;
      w_surv_n    = '0;
      w_ghsr_next = r_ghsr;
      w_rpc_next  = r_redirect_pc;
      for (int l = 0; l < LANES; l++) begin
         if (w_active[l] && !w_found) begin
            w_surv[l]  = 1'b1;
            w_surv_n   = w_surv_n + OCC_W'(1);
            w_rpc_next = w_target[l];
            if (is_branch[l]) begin
               w_ghsr_next = {w_ghsr_next[GHSR_W-2:0], w_taken[l]};
            end else begin
               w_ghsr_next = w_ghsr_next;
            end
            w_found = w_misp[l];
         end else begin
            w_surv[l] = 1'b0;
         end
      end
   end

   // Update-FIFO admission: the same-cycle pop frees a slot, overflow drops youngest first.
   always_comb begin
      w_pop     = upd_valid & upd_ready;
      w_free    = OCC_W'(UPD_DEPTH) - r_occ + {{(OCC_W-1){1'b0}}, w_pop};
      w_acc     = '0;
      w_drop    = '0;
      w_push_en = '0;
      for (int l = 0; l < LANES; l++) begin
         w_push_idx[l] = r_wptr + w_acc[PTR_W-1:0];
         if (w_surv[l]) begin
            if (w_acc < w_free) begin
               w_push_en[l] = 1'b1;
               w_acc        = w_acc + OCC_W'(1);
            end else begin
               w_drop = w_drop + OCC_W'(1);
            end
         end else begin
            w_push_en[l] = 1'b0;
         end
      end
      w_occ_next = r_occ + w_acc - {{(OCC_W-1){1'b0}}, w_pop};
   end

   // Control state, redirect, link, FIFO pointers and statistics.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ghsr           <= '0;
         r_ghsr_restore   <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 32'd0;
         r_link           <= '0;
         r_rptr           <= '0;
         r_wptr           <= '0;
         r_occ            <= '0;
         r_almost_full    <= 1'b0;
         r_resolved       <= 32'd0;
         r_misp           <= 32'd0;
         r_drop           <= 32'd0;
      end else begin
         r_ghsr           <= w_ghsr_next;
         r_ghsr_restore   <= w_ghsr_next;
         r_redirect_valid <= w_found;
         r_redirect_pc    <= w_rpc_next;
         for (int l = 0; l < LANES; l++) begin
            r_link[32*l +: 32] <= pc[32*l +: 32] + 32'd4;
         end
         r_rptr        <= r_rptr + {{(PTR_W-1){1'b0}}, w_pop};
         r_wptr        <= r_wptr + w_acc[PTR_W-1:0];
         r_occ         <= w_occ_next;
         r_almost_full <= ((OCC_W'(UPD_DEPTH) - w_occ_next) < OCC_W'(LANES));
         r_resolved    <= sat_add(r_resolved, 32'(w_surv_n));
         r_misp        <= sat_add(r_misp, {31'd0, w_found});
         r_drop        <= sat_add(r_drop, 32'(w_drop));
      end
   end

   // Update-record storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int e = 0; e < UPD_DEPTH; e++) begin
            r_mem_pc[e]  <= 32'd0;
            r_mem_tgt[e] <= 32'd0;
         end
         r_mem_taken <= '0;
         r_mem_cond  <= '0;
      end else begin
         for (int l = 0; l < LANES; l++) begin
            if (w_push_en[l]) begin
               r_mem_pc[w_push_idx[l]]    <= pc[32*l +: 32];
               r_mem_tgt[w_push_idx[l]]   <= w_target[l];
               r_mem_taken[w_push_idx[l]] <= w_taken[l];
               r_mem_cond[w_push_idx[l]]  <= is_branch[l];
            end else begin
               r_mem_pc[w_push_idx[l]] <= r_mem_pc[w_push_idx[l]];
            end
         end
      end
   end

   assign redirect_valid  = r_redirect_valid;
   assign redirect_pc     = r_redirect_pc;
   assign link_pc         = r_link;
   assign ghsr_restore    = r_ghsr_restore;
   assign upd_valid       = (r_occ != '0);
   assign upd_pc          = r_mem_pc[r_rptr];
   assign upd_target      = r_mem_tgt[r_rptr];
   assign upd_taken       = r_mem_taken[r_rptr];
   assign upd_is_cond     = r_mem_cond[r_rptr];
   assign upd_almost_full = r_almost_full;
   assign resolved_cnt    = r_resolved;
   assign mispredict_cnt  = r_misp;
   assign drop_cnt        = r_drop;
endmodule

// File: tb/tb_bju_resolve.sv
// Directed self-checking bench for bju_resolve (LANES=2, GHSR_W=8, UPD_DEPTH=8).
module tb_bju_resolve;
   logic        clk = 1'b0;
   logic        reset_n, flush_in, upd_ready;
   logic [1:0]  lane_valid, is_branch, is_jump, is_jumpr, pred_taken, pred_hit;
   logic [5:0]  funct3;
   logic [63:0] pc, rs1, rs2, imm, pred_target, link_pc;
   logic        redirect_valid, upd_valid, upd_taken, upd_is_cond, upd_almost_full;
   logic [31:0] redirect_pc, upd_pc, upd_target, resolved_cnt, mispredict_cnt, drop_cnt;
   logic [7:0]  ghsr_restore;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_pc [8];
   logic [31:0] exp_tg [8];

   bju_resolve #(.LANES(2), .GHSR_W(8), .UPD_DEPTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .flush_in(flush_in), .lane_valid(lane_valid),
      .is_branch(is_branch), .is_jump(is_jump), .is_jumpr(is_jumpr), .funct3(funct3),
      .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm), .pred_taken(pred_taken), .pred_hit(pred_hit),
      .pred_target(pred_target), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .link_pc(link_pc), .ghsr_restore(ghsr_restore), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken), .upd_is_cond(upd_is_cond),
      .upd_almost_full(upd_almost_full), .resolved_cnt(resolved_cnt),
      .mispredict_cnt(mispredict_cnt), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_lanes();
      lane_valid = 2'b00; is_branch = 2'b00; is_jump = 2'b00; is_jumpr = 2'b00;
      pred_taken = 2'b00; pred_hit = 2'b00; funct3 = 6'd0; flush_in = 1'b0;
      pc = 64'd0; rs1 = 64'd0; rs2 = 64'd0; imm = 64'd0; pred_target = 64'd0;
   endtask

   task automatic set_lane(input int l, input logic br, input logic j, input logic jr,
                           input logic [2:0] f3, input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] i, input logic pt,
                           input logic ph, input logic [31:0] ptg);
      lane_valid[l] = 1'b1; is_branch[l] = br; is_jump[l] = j; is_jumpr[l] = jr;
      funct3[3*l +: 3] = f3; pc[32*l +: 32] = p; rs1[32*l +: 32] = a; rs2[32*l +: 32] = b;
      imm[32*l +: 32] = i; pred_taken[l] = pt; pred_hit[l] = ph; pred_target[32*l +: 32] = ptg;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; upd_ready = 1'b0;
      clear_lanes();
      #1;
      check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
      check("rst_ghsr", {24'd0, ghsr_restore}, 32'd0);
      check("rst_resolved", resolved_cnt, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // BEQ taken, predicted not-taken
      set_lane(0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 1'b0, 32'd0);
      step(); clear_lanes();
      check("beq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      check("beq_redirect_pc", redirect_pc, 32'h120);
      check("beq_misp_cnt", mispredict_cnt, 32'd1);
      check("beq_resolved", resolved_cnt, 32'd1);
      check("beq_ghsr", {24'd0, ghsr_restore}, 32'h01);
      check("beq_link0", link_pc[31:0], 32'h104);
      check("beq_upd_pc", upd_pc, 32'h100);
      check("beq_upd_target", upd_target, 32'h120);
      check("beq_upd_flags", {30'd0, upd_taken, upd_is_cond}, 32'd3);

      // BNE mispredicts, younger JAL squashed
      set_lane(0, 1'b1, 1'b0, 1'b0, 3'd1, 32'h200, 32'd1, 32'd1, 32'h40, 1'b1, 1'b0, 32'd0);
      set_lane(1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h204, 32'd0, 32'd0, 32'h100, 1'b1, 1'b1, 32'h304);
      step(); clear_lanes();
      check("bne_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      check("bne_redirect_pc", redirect_pc, 32'h204);
      check("bne_resolved", resolved_cnt, 32'd2);
      check("bne_misp_cnt", mispredict_cnt, 32'd2);
      check("bne_ghsr", {24'd0, ghsr_restore}, 32'h02);
      check("bne_link1", link_pc[63:32], 32'h208);
      check("bne_head", upd_pc, 32'h100);

      // JALR correctly predicted, bit 0 cleared
      set_lane(0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h300, 32'h203, 32'd0, 32'h10, 1'b1, 1'b1, 32'h212);
      step(); clear_lanes();
      check("jalr_no_redirect", {31'd0, redirect_valid}, 32'd0);
      check("jalr_redirect_pc", redirect_pc, 32'h212);
      check("jalr_ghsr", {24'd0, ghsr_restore}, 32'h02);
      check("jalr_resolved", resolved_cnt, 32'd3);

      // BLTU not-taken (correct) then BGE not-taken (mispredicted)
      set_lane(0, 1'b1, 1'b0, 1'b0, 3'd6, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 1'b0, 32'd0);
      set_lane(1, 1'b1, 1'b0, 1'b0, 3'd5, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 1'b0, 32'd0);
      step(); clear_lanes();
      check("bge_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      check("bge_redirect_pc", redirect_pc, 32'h504);
      check("bge_ghsr", {24'd0, ghsr_restore}, 32'h08);
      check("bge_resolved", resolved_cnt, 32'd5);

      // BLT taken with wrong BTB target; lane1 squashed
      set_lane(0, 1'b1, 1'b0, 1'b0, 3'd4, 32'h600, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b1, 1'b1, 32'h640);
      set_lane(1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h6F0, 32'd0, 32'd0, 32'h8, 1'b0, 1'b0, 32'd0);
      step(); clear_lanes();
      check("blt_redirect_pc", redirect_pc, 32'h620);
      check("blt_misp_cnt", mispredict_cnt, 32'd4);
      check("blt_ghsr", {24'd0, ghsr_restore}, 32'h11);
      check("blt_almost_full", {31'd0, upd_almost_full}, 32'd0);

      // Two correct JALs fill the FIFO
      set_lane(0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h700, 32'd0, 32'd0, 32'h4, 1'b1, 1'b0, 32'd0);
      set_lane(1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h800, 32'd0, 32'd0, 32'h8, 1'b1, 1'b0, 32'd0);
      step(); clear_lanes();
      check("fill_almost_full", {31'd0, upd_almost_full}, 32'd1);
      check("fill_drop", drop_cnt, 32'd0);

      // Full, no pop: both records dropped
      set_lane(0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h7A0, 32'd0, 32'd0, 32'h4, 1'b1, 1'b0, 32'd0);
      set_lane(1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h8A0, 32'd0, 32'd0, 32'h8, 1'b1, 1'b0, 32'd0);
      step(); clear_lanes();
      check("full_drop", drop_cnt, 32'd2);
      check("full_almost_full", {31'd0, upd_almost_full}, 32'd1);
      check("full_head", upd_pc, 32'h100);
      check("full_resolved", resolved_cnt, 32'd10);

      // Full with pop: one slot freed, lane1 dropped
      upd_ready = 1'b1;
      set_lane(0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h900, 32'd0, 32'd0, 32'h0, 1'b1, 1'b0, 32'd0);
      set_lane(1, 1'b0, 1'b1, 1'b0, 3'd0, 32'hA00, 32'd0, 32'd0, 32'h0, 1'b1, 1'b0, 32'd0);
      step(); clear_lanes(); upd_ready = 1'b0;
      check("poppush_drop", drop_cnt, 32'd3);
      check("poppush_head_pc", upd_pc, 32'h200);
      check("poppush_head_tgt", upd_target, 32'h204);
      check("poppush_head_flags", {30'd0, upd_taken, upd_is_cond}, 32'd1);

      // Flush kills two mispredicting lanes
      set_lane(0, 1'b1, 1'b0, 1'b0, 3'd0, 32'hB00, 32'd3, 32'd3, 32'h40, 1'b0, 1'b0, 32'd0);
      set_lane(1, 1'b1, 1'b0, 1'b0, 3'd0, 32'hC00, 32'd3, 32'd3, 32'h40, 1'b0, 1'b0, 32'd0);
      flush_in = 1'b1;
      step(); clear_lanes();
      check("flush_redirect", {31'd0, redirect_valid}, 32'd0);
      check("flush_resolved", resolved_cnt, 32'd12);
      check("flush_misp", mispredict_cnt, 32'd4);
      check("flush_drop", drop_cnt, 32'd3);
      check("flush_ghsr", {24'd0, ghsr_restore}, 32'h11);
      check("flush_head", upd_pc, 32'h200);

      // Drain and check record order
      exp_pc = '{32'h200, 32'h300, 32'h400, 32'h500, 32'h600, 32'h700, 32'h800, 32'h900};
      exp_tg = '{32'h204, 32'h212, 32'h404, 32'h504, 32'h620, 32'h704, 32'h808, 32'h900};
      upd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_pc%0d", i), upd_pc, exp_pc[i]);
         check($sformatf("drain_tgt%0d", i), upd_target, exp_tg[i]);
         step();
      end
      upd_ready = 1'b0;
      check("drain_empty", {31'd0, upd_valid}, 32'd0);
      check("drain_almost_full", {31'd0, upd_almost_full}, 32'd0);

      // Asynchronous reset mid-cycle with pending redirect and queued record
      set_lane(0, 1'b0, 1'b1, 1'b0, 3'd0, 32'hD00, 32'd0, 32'd0, 32'h10, 1'b0, 1'b0, 32'd0);
      step(); clear_lanes();
      check("pre_rst_redirect", {31'd0, redirect_valid}, 32'd1);
      check("pre_rst_upd_valid", {31'd0, upd_valid}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_redirect", {31'd0, redirect_valid}, 32'd0);
      check("arst_redirect_pc", redirect_pc, 32'd0);
      check("arst_upd_valid", {31'd0, upd_valid}, 32'd0);
      check("arst_link0", link_pc[31:0], 32'd0);
      check("arst_ghsr", {24'd0, ghsr_restore}, 32'd0);
      check("arst_counts", resolved_cnt | mispredict_cnt | drop_cnt, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      set_lane(0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 1'b0, 32'd0);
      step(); clear_lanes();
      check("post_rst_redirect", {31'd0, redirect_valid}, 32'd1);
      check("post_rst_redirect_pc", redirect_pc, 32'h120);
      check("post_rst_misp", mispredict_cnt, 32'd1);
      check("post_rst_ghsr", {24'd0, ghsr_restore}, 32'h01);
      step();
      check("pulse_one_cycle", {31'd0, redirect_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
